// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and decode helpers for the RV32M multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} muldiv_state_t;
  function automatic logic is_div(muldiv_op_t op);
    return op[2];
  endfunction
  function automatic logic is_signed_rs1(muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic is_signed_rs2(muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (multiply) or restore-subtract (divide) iteration on a {hi, lo} accumulator
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                div,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   acc_nx
);
  logic [XLEN:0] sum, shifted, diff;
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand & {XLEN{acc[0]}}};
    shifted = acc[2*XLEN-1:XLEN-1];
    diff    = shifted - {1'b0, operand};
    acc_nx  = div ? {(diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0]), acc[XLEN-2:0], ~diff[XLEN]}
                  : {sum, acc[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit, UNROLL iterations per clock
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  muldiv_state_t state, state_nx;
  muldiv_op_t op, op_in;
  logic neg1, neg2, neg1_in, neg2_in, accept, div_zero, div_ovf, last;
  logic [XLEN-1:0] mag1_in, mag2_in, opnd, special_res, final_res, quot, rem;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [2*XLEN-1:0] chain [UNROLL+1];
  logic [CW-1:0] cnt;
  assign op_in    = muldiv_op_t'(fun3);
  assign neg1_in  = is_signed_rs1(op_in) & rs1[XLEN-1];
  assign neg2_in  = is_signed_rs2(op_in) & rs2[XLEN-1];
  assign mag1_in  = neg1_in ? -rs1 : rs1;
  assign mag2_in  = neg2_in ? -rs2 : rs2;
  assign in_ready = state == S_IDLE;
  assign busy     = state != S_IDLE;
  assign accept   = in_valid & in_ready & ~flush;
  assign div_zero = is_div(op_in) && rs2 == '0;
  assign div_ovf  = is_div(op_in) && is_signed_rs2(op_in) && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
  assign special_res = div_zero ? (fun3[1] ? rs1 : '1) : (fun3[1] ? '0 : rs1);
  assign last     = cnt == CW'(STEPS - 1);
  assign chain[0] = acc;
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div     (is_div(op)),
      .acc     (chain[i]),
      .operand (opnd),
      .acc_nx  (chain[i+1])
    );
  end
  assign acc_nx = chain[UNROLL];
  // sign fix is applied to the final iteration's output as it is captured into result
  assign prod      = (neg1 ^ neg2) ? -acc_nx : acc_nx;
  assign quot      = (neg1 ^ neg2) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
  assign rem       = neg1 ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
  assign final_res = is_div(op) ? (op inside {OP_REM, OP_REMU} ? rem : quot)
                                : (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = accept ? ((div_zero | div_ovf) ? S_DONE : S_CALC) : S_IDLE;
      S_CALC:  state_nx = last ? S_DONE : S_CALC;
      S_DONE:  state_nx = out_ready ? S_IDLE : S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op        <= OP_MUL;
      neg1      <= 1'b0;
      neg2      <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= state_nx == S_DONE;
      if (accept) begin
        op   <= op_in;
        neg1 <= neg1_in;
        neg2 <= neg2_in;
        cnt  <= '0;
        opnd <= is_div(op_in) ? mag2_in : mag1_in;
        acc  <= {{XLEN{1'b0}}, is_div(op_in) ? mag1_in : mag2_in};
        if (div_zero | div_ovf) result <= special_res;
      end else if (state == S_CALC && !flush) begin
        acc <= acc_nx;
        cnt <= cnt + CW'(1);
        if (last) result <= final_res;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks at UNROLL=1 and model-based random checks at UNROLL=4
module tb_muldiv_unit;
  logic clk = 0, reset = 1;
  logic in_valid_a = 0, out_ready_a = 0, flush_a = 0;
  logic in_ready_a, out_valid_a, busy_a;
  logic [2:0] fun3_a = 0;
  logic [31:0] rs1_a = 0, rs2_a = 0, result_a;
  logic in_valid_b = 0, out_ready_b = 0;
  logic in_ready_b, out_valid_b, busy_b;
  logic [2:0] fun3_b = 0;
  logic [31:0] rs1_b = 0, rs2_b = 0, result_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a), .fun3(fun3_a),
    .rs1(rs1_a), .rs2(rs2_a), .flush(flush_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .result(result_a), .busy(busy_a));
  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .fun3(fun3_b),
    .rs1(rs1_b), .rs2(rs2_b), .flush(1'b0), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .result(result_b), .busy(busy_b));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    up = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  task automatic op_a(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat);
    fun3_a = f; rs1_a = a; rs2_a = b; in_valid_a = 1;
    @(posedge clk); #1 in_valid_a = 0; lat = 1;
    while (!out_valid_a && lat < 200) begin @(posedge clk); #1 lat++; end
    res = result_a;
  endtask
  task automatic release_a;
    out_ready_a = 1;
    @(posedge clk); #1 out_ready_a = 0;
  endtask
  task automatic op_b(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat);
    fun3_b = f; rs1_b = a; rs2_b = b; in_valid_b = 1;
    @(posedge clk); #1 in_valid_b = 0; lat = 1;
    while (!out_valid_b && lat < 200) begin @(posedge clk); #1 lat++; end
    res = result_b;
    out_ready_b = 1;
    @(posedge clk); #1 out_ready_b = 0;
  endtask
  typedef struct {string tag; logic [2:0] f; logic [31:0] a, b, exp; int lat;} vec_t;
  vec_t vecs[12] = '{
    '{"mul",       3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33},
    '{"mulh",      3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33},
    '{"mulhu",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
    '{"mulhsu",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33},
    '{"div",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33},
    '{"rem",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33},
    '{"divu",      3'd5, 32'd100,      32'd7,        32'd14,       33},
    '{"remu",      3'd7, 32'd100,      32'd7,        32'd2,        33},
    '{"div_zero",  3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
    '{"remu_zero", 3'd7, 32'd5,        32'd0,        32'd5,        1},
    '{"div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
    '{"rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1}
  };
  initial begin
    logic [31:0] res, a, b, prev;
    logic [2:0] f;
    int lat, stray;
    #1;
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_result", result_a, 0);
    @(posedge clk); #1 reset = 0;
    foreach (vecs[i]) begin
      op_a(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].tag, "_res"}, res, vecs[i].exp);
      check({vecs[i].tag, "_lat"}, lat, vecs[i].lat);
      release_a();
      check({vecs[i].tag, "_idle"}, in_ready_a, 1);
    end
    op_a(3'd5, 32'd1000, 32'd9, res, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid_a, 1);
      check("hold_result", result_a, 32'd111);
    end
    release_a();
    prev = result_a;
    fun3_a = 3'd0; rs1_a = 32'd3; rs2_a = 32'd5; in_valid_a = 1;
    @(posedge clk); #1 in_valid_a = 0;
    repeat (11) @(posedge clk);
    #1 flush_a = 1;
    @(posedge clk); #1 flush_a = 0;
    check("flush_in_ready", in_ready_a, 1);
    check("flush_busy", busy_a, 0);
    check("flush_valid", out_valid_a, 0);
    stray = 0;
    repeat (40) begin @(posedge clk); #1 if (out_valid_a) stray++; end
    check("flush_no_valid", stray, 0);
    check("flush_result", result_a, prev);
    fun3_a = 3'd1; rs1_a = 32'd9; rs2_a = 32'd9; in_valid_a = 1;
    @(posedge clk); #1 in_valid_a = 0;
    repeat (5) @(posedge clk);
    #2 reset = 1;
    #1;
    check("midrst_in_ready", in_ready_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_valid", out_valid_a, 0);
    check("midrst_result", result_a, 0);
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 500; i++) begin
      f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      op_b(f, a, b, res, lat);
      check("rnd_res", res, ref_op(f, a, b));
      check("rnd_lat", lat, (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 9);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
